// File: rtl/lb_uart_rx_gen2_if.sv
// Signal bundle for lb_uart_rx_gen2: serial line, per-frame configuration and held-frame handshake.
// The receiver uses the master modport; the consumer/driver side uses slave.
interface lb_uart_rx_gen2_if #(
    parameter int DATA_MAX = 9,
    parameter int BAUD_W   = 20
);
    logic [BAUD_W-1:0]   baud_value;
    logic [3:0]          data_len;
    logic                parity_en;
    logic                odd_n_even;
    logic                stop2;
    logic                cs;
    logic                rx;
    logic                rx_ready;
    logic [DATA_MAX-1:0] data_out;
    logic                rx_valid;
    logic                parity_err;
    logic                stop_err;
    logic                break_det;
    logic                overrun_err;
    logic                busy;

    modport master (
        input  baud_value, data_len, parity_en, odd_n_even, stop2, cs, rx, rx_ready,
        output data_out, rx_valid, parity_err, stop_err, break_det, overrun_err, busy
    );

    modport slave (
        output baud_value, data_len, parity_en, odd_n_even, stop2, cs, rx, rx_ready,
        input  data_out, rx_valid, parity_err, stop_err, break_det, overrun_err, busy
    );
endinterface

// File: rtl/lb_uart_rx_gen2.sv
// UART receiver with per-frame latched configuration and a single held-frame output register.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote around the nominal sample.
module lb_uart_rx_gen2 #(
    parameter int DATA_MAX = 9,
    parameter int BAUD_W   = 20
) (
    input  logic              clk,
    input  logic              reset,
    lb_uart_rx_gen2_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0] LEN_MAX = 4'(DATA_MAX);

    state_t              r_state;
    logic [1:0]          r_sync;
    logic                r_rxPrev;
    logic [BAUD_W-1:0]   r_cnt;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   r_half;
    logic [3:0]          r_len;
    logic [3:0]          r_bitIdx;
    logic                r_parEn;
    logic                r_odd;
    logic                r_stop2;
    logic                r_stopIdx;
    logic [DATA_MAX-1:0] r_data;
    logic                r_parAcc;
    logic                r_allZero;
    logic                r_sErr;
    logic                r_brk;
    logic                r_commit;

    logic [DATA_MAX-1:0] r_dout;
    logic                r_valid;
    logic                r_pErrOut;
    logic                r_sErrOut;
    logic                r_brkOut;
    logic                r_ovr;

    logic                w_rx;
    logic                w_nominal;
    logic                w_bitEvt;
    logic                w_bitVal;
    logic                w_start;
    logic [BAUD_W-1:0]   w_target;
    logic [3:0]          w_lenClamp;

    assign w_rx       = r_sync[1];
    assign w_target   = (r_state == START) ? r_half : r_baud;
    assign w_nominal  = (r_state != IDLE) && (r_cnt == w_target);
    assign w_start    = bus.cs && r_rxPrev && !w_rx;
    assign w_lenClamp = (bus.data_len < 4'd5)     ? 4'd5    :
                        (bus.data_len > LEN_MAX)  ? LEN_MAX : bus.data_len;

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample one cycle after nominal, so bit decisions land one cycle late.
    logic [1:0] r_hist;
    logic       r_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= 2'b11;
            r_pend <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], w_rx};
            r_pend <= w_nominal;
        end
    end

    assign w_bitEvt = r_pend;
    assign w_bitVal = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
`else
    assign w_bitEvt = w_nominal;
    assign w_bitVal = w_rx;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= 2'b11;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], bus.rx};
            r_rxPrev <= w_rx;
        end
    end

    // Counter restarts at every nominal sample so later samples stay exactly one bit period apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_baud    <= '0;
            r_half    <= '0;
            r_len     <= 4'd0;
            r_bitIdx  <= 4'd0;
            r_parEn   <= 1'b0;
            r_odd     <= 1'b0;
            r_stop2   <= 1'b0;
            r_stopIdx <= 1'b0;
            r_data    <= '0;
            r_parAcc  <= 1'b0;
            r_allZero <= 1'b0;
            r_sErr    <= 1'b0;
            r_brk     <= 1'b0;
            r_commit  <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (r_state != IDLE) begin
                r_cnt <= w_nominal ? BAUD_W'(1) : r_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state   <= START;
                        r_cnt     <= BAUD_W'(1);
                        r_baud    <= bus.baud_value;
                        r_half    <= bus.baud_value >> 1;
                        r_len     <= w_lenClamp;
                        r_parEn   <= bus.parity_en;
                        r_odd     <= bus.odd_n_even;
                        r_stop2   <= bus.stop2;
                        r_bitIdx  <= 4'd0;
                        r_stopIdx <= 1'b0;
                        r_data    <= '0;
                        r_parAcc  <= 1'b0;
                        r_allZero <= 1'b1;
                        r_sErr    <= 1'b0;
                        r_brk     <= 1'b0;
                    end
                end
                START: begin
                    if (w_bitEvt) begin
                        r_state <= w_bitVal ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_bitEvt) begin
                        for (int i = 0; i < DATA_MAX; i++) begin
                            if (r_bitIdx == 4'(i)) begin
                                r_data[i] <= w_bitVal;
                            end
                        end
                        r_parAcc  <= r_parAcc ^ w_bitVal;
                        r_allZero <= r_allZero & ~w_bitVal;
                        if (r_bitIdx == r_len - 4'd1) begin
                            r_state <= r_parEn ? PARITY : STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_bitEvt) begin
                        r_parAcc  <= r_parAcc ^ w_bitVal;
                        r_allZero <= r_allZero & ~w_bitVal;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_bitEvt) begin
                        r_sErr <= r_sErr | ~w_bitVal;
                        if (!r_stopIdx) begin
                            r_brk <= r_allZero & ~w_bitVal;
                        end
                        if (r_stop2 && !r_stopIdx) begin
                            r_stopIdx <= 1'b1;
                        end else begin
                            r_commit <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A commit that collides with an unaccepted held frame is dropped and flagged as overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_pErrOut <= 1'b0;
            r_sErrOut <= 1'b0;
            r_brkOut  <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_commit) begin
                if (!r_valid || bus.rx_ready) begin
                    r_dout    <= r_data;
                    r_valid   <= 1'b1;
                    r_pErrOut <= r_parEn & (r_parAcc != r_odd);
                    r_sErrOut <= r_sErr;
                    r_brkOut  <= r_brk;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data_out    = r_dout;
    assign bus.rx_valid    = r_valid;
    assign bus.parity_err  = r_pErrOut;
    assign bus.stop_err    = r_sErrOut;
    assign bus.break_det   = r_brkOut;
    assign bus.overrun_err = r_ovr;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_lb_uart_rx_gen2.sv
// Scoreboard bench for lb_uart_rx_gen2: directed scenarios plus randomized frames against a frame-level model.
module tb_lb_uart_rx_gen2;
    localparam int DATA_MAX = 9;
    localparam int BAUD_W   = 20;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       se;
        logic       bd;
    } frame_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lb_uart_rx_gen2_if #(.DATA_MAX(DATA_MAX), .BAUD_W(BAUD_W)) bus ();

    lb_uart_rx_gen2 #(.DATA_MAX(DATA_MAX), .BAUD_W(BAUD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    frame_t      sbQ[$];
    frame_t      monExp;
    int          nChecks   = 0;
    int          nFail     = 0;
    int          ovrCycles = 0;
    int          expOvr    = 0;
    logic [12:0] prevHeld;
    bit          prevHeldValid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        nChecks++;
        if (act !== want) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Expected frame from the line-level rules: clamp length, mask data, derive status flags.
    function automatic frame_t modelFrame(input logic [8:0] word, input int lenIn, input bit parEn,
                                          input bit odd, input bit pBit, input bit s1, input bit s2,
                                          input bit st2);
        frame_t f;
        int     len;
        int     ones;
        len    = (lenIn < 5) ? 5 : ((lenIn > DATA_MAX) ? DATA_MAX : lenIn);
        f.data = word & 9'((1 << len) - 1);
        ones   = $countones(f.data) + (parEn ? int'(pBit) : 0);
        f.pe   = parEn && ((ones % 2) != int'(odd));
        f.se   = !s1 || (st2 && !s2);
        f.bd   = (f.data == 9'd0) && !(parEn && pBit) && !s1;
        return f;
    endfunction

    task automatic applyStimulus(input int baud, input logic [8:0] word, input int lenIn,
                                 input bit parEn, input bit odd, input bit pBit, input bit s1,
                                 input bit s2, input bit st2, input int glitchAt,
                                 input bit scramble, input bit pushExp);
        logic bits[$];
        int   len;
        int   cyc;
        len = (lenIn < 5) ? 5 : ((lenIn > DATA_MAX) ? DATA_MAX : lenIn);
        bus.baud_value = BAUD_W'(baud);
        bus.data_len   = 4'(lenIn);
        bus.parity_en  = parEn;
        bus.odd_n_even = odd;
        bus.stop2      = st2;
        bus.cs         = 1'b1;
        bits.push_back(1'b0);
        for (int i = 0; i < len; i++) bits.push_back(word[i]);
        if (parEn) bits.push_back(pBit);
        bits.push_back(s1);
        if (st2) bits.push_back(s2);
        if (pushExp) sbQ.push_back(modelFrame(word, lenIn, parEn, odd, pBit, s1, s2, st2));
        cyc = 0;
        foreach (bits[k]) begin
            for (int c = 0; c < baud; c++) begin
                @(posedge clk);
                #1;
                bus.rx = (cyc == glitchAt) ? ~bits[k] : bits[k];
                if (scramble && k == 2 && c == 0) begin
                    bus.baud_value = BAUD_W'($urandom_range(30, 4));
                    bus.data_len   = 4'($urandom);
                    bus.parity_en  = 1'($urandom);
                    bus.odd_n_even = 1'($urandom);
                    bus.stop2      = 1'($urandom);
                    bus.cs         = 1'b0;
                end
                cyc++;
            end
        end
        @(posedge clk);
        #1;
        bus.rx = 1'b1;
        bus.cs = 1'b1;
    endtask

    // Monitor: pops an expected frame on every accept handshake and checks held-frame stability.
    always @(negedge clk) begin
        if (reset) begin
            prevHeldValid = 1'b0;
        end else begin
            if (bus.overrun_err) ovrCycles++;
            if (prevHeldValid) begin
                checkOutput("held_stable",
                            {bus.rx_valid, bus.data_out, bus.parity_err, bus.stop_err, bus.break_det},
                            prevHeld);
            end
            if (bus.rx_valid && bus.rx_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_frame", {23'd0, bus.data_out}, 32'hFFFF_FFFF);
                end else begin
                    monExp = sbQ.pop_front();
                    checkOutput("frame_data", {23'd0, bus.data_out}, {23'd0, monExp.data});
                    checkOutput("frame_parity_err", {31'd0, bus.parity_err}, {31'd0, monExp.pe});
                    checkOutput("frame_stop_err", {31'd0, bus.stop_err}, {31'd0, monExp.se});
                    checkOutput("frame_break_det", {31'd0, bus.break_det}, {31'd0, monExp.bd});
                end
            end
            prevHeldValid = bus.rx_valid && !bus.rx_ready;
            prevHeld      = {bus.rx_valid, bus.data_out, bus.parity_err, bus.stop_err, bus.break_det};
        end
    end

    initial begin
        int  baud;
        bit  sawBusy;
        frame_t g;

        reset          = 1'b1;
        bus.rx         = 1'b1;
        bus.rx_ready   = 1'b1;
        bus.cs         = 1'b1;
        bus.baud_value = BAUD_W'(16);
        bus.data_len   = 4'd8;
        bus.parity_en  = 1'b0;
        bus.odd_n_even = 1'b0;
        bus.stop2      = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_data_out", {23'd0, bus.data_out}, 32'd0);
        checkOutput("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        checkOutput("reset_parity_err", {31'd0, bus.parity_err}, 32'd0);
        checkOutput("reset_stop_err", {31'd0, bus.stop_err}, 32'd0);
        checkOutput("reset_break_det", {31'd0, bus.break_det}, 32'd0);
        checkOutput("reset_overrun", {31'd0, bus.overrun_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] clean frame and parity frames");
        applyStimulus(16, 9'h0A5, 8, 0, 0, 0, 1, 1, 0, -1, 0, 1);
        repeat (5) @(posedge clk);
        applyStimulus(16, 9'h041, 7, 1, 1, 0, 1, 1, 0, -1, 0, 1);
        repeat (5) @(posedge clk);
        applyStimulus(16, 9'h041, 7, 1, 1, 1, 1, 1, 0, -1, 0, 1);
        repeat (5) @(posedge clk);

        $display("[TB] false start");
        @(posedge clk);
        #1 bus.rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.rx = 1'b1;
        sawBusy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) sawBusy = 1'b1;
        end
        checkOutput("false_start_busy_seen", {31'd0, sawBusy}, 32'd1);
        checkOutput("false_start_busy_idle", {31'd0, bus.busy}, 32'd0);
        checkOutput("false_start_no_valid", {31'd0, bus.rx_valid}, 32'd0);

        $display("[TB] overrun");
        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
        applyStimulus(16, 9'h011, 8, 0, 0, 0, 1, 1, 0, -1, 0, 1);
        repeat (5) @(posedge clk);
        applyStimulus(16, 9'h022, 8, 0, 0, 0, 1, 1, 0, -1, 0, 0);
        expOvr++;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("overrun_held_data", {23'd0, bus.data_out}, 32'h011);
        checkOutput("overrun_held_valid", {31'd0, bus.rx_valid}, 32'd1);
        checkOutput("overrun_pulse_cycles", ovrCycles, expOvr);
        @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
        @(negedge clk);
        checkOutput("accept_clears_valid", {31'd0, bus.rx_valid}, 32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(16, 9'h033, 8, 0, 0, 0, 1, 1, 0, -1, 0, 0);
        repeat (5) @(posedge clk);
        #1 bus.rx = 1'b0;
        repeat (40) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 bus.rx = 1'b1;
        @(negedge clk);
        checkOutput("midframe_reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midframe_reset_valid", {31'd0, bus.rx_valid}, 32'd0);
        checkOutput("midframe_reset_data", {23'd0, bus.data_out}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.rx_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("midframe_reset_no_commit", {31'd0, bus.rx_valid}, 32'd0);

        $display("[TB] break");
        sbQ.push_back(modelFrame(9'h000, 8, 0, 0, 0, 0, 0, 0));
        bus.baud_value = BAUD_W'(16);
        bus.data_len   = 4'd8;
        bus.parity_en  = 1'b0;
        bus.stop2      = 1'b0;
        @(posedge clk);
        #1 bus.rx = 1'b0;
        repeat (12 * 16) @(posedge clk);
        @(negedge clk);
        checkOutput("break_no_second_frame_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1 bus.rx = 1'b1;
        repeat (40) @(posedge clk);

        $display("[TB] glitch on bit 3");
        g.data = 9'h000;
`ifndef UART_RX_MAJORITY_EN
        g.data = 9'h008;
`endif
        g.pe = 1'b0;
        g.se = 1'b0;
        g.bd = 1'b0;
        sbQ.push_back(g);
        applyStimulus(16, 9'h000, 8, 0, 0, 0, 1, 1, 0, 8 + 4 * 16, 0, 0);
        repeat (5) @(posedge clk);

        $display("[TB] randomized frames");
        for (int n = 0; n < 30; n++) begin
            baud = $urandom_range(24, 4);
            applyStimulus(baud, 9'($urandom), $urandom_range(15, 0), 1'($urandom), 1'($urandom),
                          1'($urandom), ($urandom_range(7, 0) != 0), ($urandom_range(7, 0) != 0),
                          1'($urandom), -1, 1'($urandom), 1);
            repeat ($urandom_range(10, 3)) @(posedge clk);
        end

        for (int i = 0; i < 500 && sbQ.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", sbQ.size(), 32'd0);
        checkOutput("overrun_total_cycles", ovrCycles, expOvr);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
